// File: rtl/wishbone_rr_arbiter.sv
`timescale 1ns/1ps
// wishbone_rr_arbiter
// Shares one Wishbone DRAM port between NUM_MASTERS masters using a
// round-robin pointer. A registered one-hot grant selects the master whose
// request is copied onto the slave port. Every transaction is followed by
// one dead (GAP) cycle. A per-transaction watchdog forces a retry to the
// granted master when the slave never answers.
module wishbone_rr_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 128,
  parameter int TIMEOUT     = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  // master side
  input  logic [NUM_MASTERS-1:0]          m_cyc,
  input  logic [NUM_MASTERS-1:0]          m_stb,
  input  logic [NUM_MASTERS-1:0]          m_we,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_sel,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_adr,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_dat_m,
  output logic [NUM_MASTERS-1:0]          m_ack,
  output logic [NUM_MASTERS-1:0]          m_rty,
  output logic [DATA_W-1:0]               m_dat_s,
  // slave (DRAM) side
  output logic                            s_cyc,
  output logic                            s_stb,
  output logic                            s_we,
  output logic [DATA_W/8-1:0]             s_sel,
  output logic [ADDR_W-1:0]               s_adr,
  output logic [DATA_W-1:0]               s_dat_m,
  input  logic                            s_ack,
  input  logic                            s_rty,
  input  logic [DATA_W-1:0]               s_dat_s,
  // status
  output logic [NUM_MASTERS-1:0]          grant,
  output logic [NUM_MASTERS-1:0]          timeout_flag,
  input  logic                            timeout_clr
);

  localparam int SEL_W = DATA_W / 8;
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] grant_next;
  logic [NUM_MASTERS-1:0] flag_set;
  logic [IDX_W-1:0]       ptr, ptr_next;
  logic [IDX_W-1:0]       gidx, gidx_next;
  logic [IDX_W:0]         pick;
  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;
  logic [WD_W-1:0]        wd, wd_next;

  // signals of the currently granted master
  logic                   g_cyc, g_stb, g_we;
  logic [SEL_W-1:0]       g_sel;
  logic [ADDR_W-1:0]      g_adr;
  logic [DATA_W-1:0]      g_dat;

  logic                   in_grant;
  logic                   resp;
  logic                   fire;

  // First requesting master at or after 'start', wrapping modulo NUM_MASTERS.
  // Result is {found, index}.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_MASTERS-1:0] r,
                                             input logic [IDX_W-1:0]       start);
    logic [IDX_W:0] res;
    logic           found;
    int             c;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      c = int'(start) + k;
      if (c >= NUM_MASTERS) c = c - NUM_MASTERS;
      if (!found && r[IDX_W'(c)]) begin
        found = 1'b1;
        res   = {1'b1, IDX_W'(c)};
      end
    end
    return res;
  endfunction

  // Successor of a master index in round-robin order.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_LAST) ? '0 : i + 1'b1;
  endfunction

  assign req       = m_cyc & m_stb;
  assign pick      = rr_pick(req, ptr);
  assign win_found = pick[IDX_W];
  assign win_idx   = pick[IDX_W-1:0];

  assign in_grant  = (state == GRANT);
  assign resp      = s_ack | s_rty;
  // Watchdog expiry only counts when the slave stays silent this cycle;
  // a real response always wins over the forced retry.
  assign fire      = in_grant && (wd == WD_LAST) && !resp;

  assign m_dat_s   = s_dat_s;

  // Select the granted master's request fields via the one-hot grant.
  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_sel = '0;
    g_adr = '0;
    g_dat = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant[i]) begin
        g_cyc = m_cyc[i];
        g_stb = m_stb[i];
        g_we  = m_we[i];
        g_sel = m_sel[i*SEL_W +: SEL_W];
        g_adr = m_adr[i*ADDR_W +: ADDR_W];
        g_dat = m_dat_m[i*DATA_W +: DATA_W];
      end
    end
  end

  // Drive the slave port and route responses; everything idles at zero
  // outside GRANT so the bus never carries X.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_sel   = '0;
    s_adr   = '0;
    s_dat_m = '0;
    m_ack   = '0;
    m_rty   = '0;
    if (in_grant) begin
      // on watchdog expiry the slave cycle is withdrawn in the same cycle
      s_cyc   = g_cyc & ~fire;
      s_stb   = g_stb & ~fire;
      s_we    = g_we;
      s_sel   = g_sel;
      s_adr   = g_adr;
      s_dat_m = g_dat;
      m_ack   = s_ack ? grant : '0;
      m_rty   = (s_rty | fire) ? grant : '0;
    end
  end

  // Next-state logic: arbitrate in IDLE/GAP, watch for the end of the
  // transaction in GRANT.
  always_comb begin
    state_next = state;
    grant_next = grant;
    ptr_next   = ptr;
    gidx_next  = gidx;
    wd_next    = wd;
    flag_set   = '0;
    case (state)
      IDLE, GAP: begin
        if (win_found) begin
          state_next          = GRANT;
          grant_next          = '0;
          grant_next[win_idx] = 1'b1;
          gidx_next           = win_idx;
          wd_next             = '0;
        end else begin
          state_next = IDLE;
          grant_next = '0;
        end
      end
      GRANT: begin
        // response, watchdog expiry and master abort all close the
        // transaction the same way; only the watchdog records a flag
        if (resp || fire || !g_cyc) begin
          state_next = GAP;
          grant_next = '0;
          ptr_next   = next_idx(gidx);
          if (fire) flag_set = grant;
        end else begin
          wd_next = (wd == '1) ? wd : wd + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  // State, grant, pointer and watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
      gidx  <= '0;
      wd    <= '0;
    end else begin
      state <= state_next;
      grant <= grant_next;
      ptr   <= ptr_next;
      gidx  <= gidx_next;
      wd    <= wd_next;
    end
  end

  // Sticky watchdog flags; a new expiry outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_flag <= '0;
    end else begin
      timeout_flag <= (timeout_clr ? '0 : timeout_flag) | flag_set;
    end
  end

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
`timescale 1ns/1ps
// Testbench for wishbone_rr_arbiter: directed scenarios followed by a
// randomized run against a transaction-level reference model.
module tb_wishbone_rr_arbiter;

  localparam int N     = 3;
  localparam int AW    = 32;
  localparam int DW    = 128;
  localparam int SW    = DW / 8;
  localparam int TO    = 8;
  localparam int BUS_W = 3 + SW + AW + DW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [N*SW-1:0] m_sel;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat_m;
  logic [N-1:0]    m_ack, m_rty;
  logic [DW-1:0]   m_dat_s;
  logic            s_cyc, s_stb, s_we;
  logic [SW-1:0]   s_sel;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat_m;
  logic            s_ack, s_rty;
  logic [DW-1:0]   s_dat_s;
  logic [N-1:0]    grant;
  logic [N-1:0]    timeout_flag;
  logic            timeout_clr;

  int checks = 0;
  int fails  = 0;

  wishbone_rr_arbiter #(
    .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel),
    .m_adr(m_adr), .m_dat_m(m_dat_m), .m_ack(m_ack), .m_rty(m_rty),
    .m_dat_s(m_dat_s),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
    .s_adr(s_adr), .s_dat_m(s_dat_m), .s_ack(s_ack), .s_rty(s_rty),
    .s_dat_s(s_dat_s),
    .grant(grant), .timeout_flag(timeout_flag), .timeout_clr(timeout_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat_m = '0;
    s_ack = 1'b0; s_rty = 1'b0; s_dat_s = '0; timeout_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [AW-1:0] a1;
    a1 = 32'h0000_1234;
    rst_n = 1'b0;
    clear_inputs();
    repeat (3) tick();
    settle();
    checks++;
    if ({s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_m} !== '0) begin
      fails++; $display("FAIL reset_bus: got %h required 0", {s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_m});
    end
    checks++;
    if ({grant, m_ack, m_rty, timeout_flag} !== '0) begin
      fails++; $display("FAIL reset_ctrl: got %h required 0", {grant, m_ack, m_rty, timeout_flag});
    end
    rst_n = 1'b1;
    tick();
    m_adr[1*AW +: AW] = a1;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    settle();
    checks++;
    if (s_cyc !== 1'b0) begin
      fails++; $display("FAIL idle_same_cycle: s_cyc=%b required 0", s_cyc);
    end
    tick();
    settle();
    checks++;
    if ({s_cyc, grant, s_adr} !== {1'b1, 3'b010, a1}) begin
      fails++; $display("FAIL first_grant: got cyc=%b grant=%b adr=%h required 1 010 %h", s_cyc, grant, s_adr, a1);
    end
    s_ack = 1'b1;
    settle();
    checks++;
    if (m_ack !== 3'b010) begin
      fails++; $display("FAIL first_ack: m_ack=%b required 010", m_ack);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_seq [4];
    int n, low, age;
    exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100; exp_seq[3] = 3'b001;
    n = 0; low = 0; age = 0;
    do_reset();
    m_cyc = 3'b111; m_stb = 3'b111;
    for (int c = 0; c < 60 && n < 4; c++) begin
      tick();
      if (grant != '0) begin
        if (age == 0) begin
          checks++;
          if (grant !== exp_seq[n]) begin
            fails++; $display("FAIL rr_order[%0d]: grant=%b required %b", n, grant, exp_seq[n]);
          end
          if (n > 0) begin
            checks++;
            if (low !== 1) begin
              fails++; $display("FAIL rr_gap[%0d]: idle cycles=%0d required 1", n, low);
            end
          end
          n++;
          low = 0;
        end
        s_ack = (age == 2);
        age++;
      end else begin
        age = 0;
        s_ack = 1'b0;
      end
      settle();
      if (!s_cyc) low++;
    end
    checks++;
    if (n !== 4) begin
      fails++; $display("FAIL rr_count: grants seen=%0d required 4", n);
    end
    clear_inputs();
  endtask

  task automatic test_routing();
    do_reset();
    m_we[2] = 1'b1;
    m_sel[2*SW +: SW] = 16'hFFFF;
    m_adr[2*AW +: AW] = 32'h0000_0100;
    m_dat_m[2*DW +: DW] = 128'hDEAD_BEEF;
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    tick();
    settle();
    checks++;
    if (grant !== 3'b100) begin
      fails++; $display("FAIL route_grant: grant=%b required 100", grant);
    end
    checks++;
    if ({s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_m} !== {3'b111, 16'hFFFF, 32'h100, 128'hDEAD_BEEF}) begin
      fails++; $display("FAIL route_bus: got %h required %h", {s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_m},
                        {3'b111, 16'hFFFF, 32'h100, 128'hDEAD_BEEF});
    end
    s_ack = 1'b1;
    settle();
    checks++;
    if ({m_ack, m_rty} !== {3'b100, 3'b000}) begin
      fails++; $display("FAIL route_ack: ack=%b rty=%b required 100 000", m_ack, m_rty);
    end
    tick();
    clear_inputs();
    settle();
    checks++;
    if ({m_ack, s_cyc, grant} !== '0) begin
      fails++; $display("FAIL route_after: ack=%b cyc=%b grant=%b required all 0", m_ack, s_cyc, grant);
    end
  endtask

  task automatic test_retry();
    do_reset();
    m_cyc = 3'b011; m_stb = 3'b011;
    tick();
    settle();
    checks++;
    if (grant !== 3'b001) begin
      fails++; $display("FAIL retry_grant0: grant=%b required 001", grant);
    end
    s_rty = 1'b1;
    settle();
    checks++;
    if ({m_rty, m_ack} !== {3'b001, 3'b000}) begin
      fails++; $display("FAIL retry_route: rty=%b ack=%b required 001 000", m_rty, m_ack);
    end
    tick();
    s_rty = 1'b0;
    settle();
    checks++;
    if ({grant, s_cyc} !== '0) begin
      fails++; $display("FAIL retry_gap: grant=%b cyc=%b required 0", grant, s_cyc);
    end
    tick();
    settle();
    checks++;
    if (grant !== 3'b010) begin
      fails++; $display("FAIL retry_next: grant=%b required 010", grant);
    end
    clear_inputs();
  endtask

  task automatic test_watchdog();
    do_reset();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    tick();
    settle();
    for (int k = 1; k <= TO; k++) begin
      if (k > 1) begin
        tick();
        settle();
      end
      checks++;
      if ({grant, m_rty} !== {3'b010, (k == TO) ? 3'b010 : 3'b000}) begin
        fails++; $display("FAIL wd_cycle[%0d]: grant=%b rty=%b", k, grant, m_rty);
      end
      if (k == TO) begin
        checks++;
        if ({s_cyc, s_stb, timeout_flag} !== 5'b0) begin
          fails++; $display("FAIL wd_fire_bus: cyc=%b stb=%b flag=%b required 0", s_cyc, s_stb, timeout_flag);
        end
      end
    end
    tick();
    m_cyc = '0; m_stb = '0;
    settle();
    checks++;
    if ({timeout_flag, grant} !== {3'b010, 3'b000}) begin
      fails++; $display("FAIL wd_flag_set: flag=%b grant=%b required 010 000", timeout_flag, grant);
    end
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    settle();
    checks++;
    if (timeout_flag !== 3'b000) begin
      fails++; $display("FAIL wd_flag_clr: flag=%b required 000", timeout_flag);
    end
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    tick();
    settle();
    for (int k = 2; k <= TO; k++) begin
      tick();
      settle();
    end
    checks++;
    if (m_rty !== 3'b010) begin
      fails++; $display("FAIL wd_second_fire: rty=%b required 010", m_rty);
    end
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    m_cyc = '0; m_stb = '0;
    settle();
    checks++;
    if (timeout_flag !== 3'b010) begin
      fails++; $display("FAIL wd_set_beats_clr: flag=%b required 010", timeout_flag);
    end
  endtask

  task automatic test_abort_reset();
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    tick();
    settle();
    checks++;
    if (grant !== 3'b001) begin
      fails++; $display("FAIL abort_grant: grant=%b required 001", grant);
    end
    tick();
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    settle();
    checks++;
    if ({s_cyc, m_ack, m_rty} !== '0) begin
      fails++; $display("FAIL abort_drop: cyc=%b ack=%b rty=%b required 0", s_cyc, m_ack, m_rty);
    end
    tick();
    settle();
    checks++;
    if ({grant, m_ack, m_rty} !== '0) begin
      fails++; $display("FAIL abort_gap: grant=%b ack=%b rty=%b required 0", grant, m_ack, m_rty);
    end
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    tick();
    settle();
    checks++;
    if ({grant, s_cyc} !== {3'b001, 1'b1}) begin
      fails++; $display("FAIL abort_regrant: grant=%b cyc=%b required 001 1", grant, s_cyc);
    end
    s_ack = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s_cyc, grant, m_ack} !== '0) begin
      fails++; $display("FAIL async_reset: cyc=%b grant=%b ack=%b required 0", s_cyc, grant, m_ack);
    end
    clear_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int owner, rr, age, hang;
    logic [N-1:0] mflags, setv, pend, done, e_ack, e_rty, e_grant;
    logic [BUS_W-1:0] e_bus;
    logic fire;
    int w;
    do_reset();
    owner = -1; rr = 0; age = 0; hang = 0;
    mflags = '0; pend = '0; done = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (pend[i] && (done[i] || ($urandom % 50) == 0)) begin
          pend[i] = 1'b0; m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
        end else if (!pend[i] && ($urandom % 3) == 0) begin
          pend[i] = 1'b1; m_cyc[i] = 1'b1; m_stb[i] = 1'b1;
          m_we[i] = 1'($urandom);
          m_sel[i*SW +: SW] = 16'($urandom);
          m_adr[i*AW +: AW] = $urandom;
          m_dat_m[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      if (hang > 0) hang--;
      else if (($urandom % 60) == 0) hang = 12 + ($urandom % 10);
      s_ack = (hang == 0) && (($urandom % 4) == 0);
      s_rty = (hang == 0) && !s_ack && (($urandom % 12) == 0);
      s_dat_s = {$urandom, $urandom, $urandom, $urandom};
      timeout_clr = (($urandom % 20) == 0);
      settle();
      // expected outputs for this cycle
      e_bus = '0; e_ack = '0; e_rty = '0; e_grant = '0; fire = 1'b0;
      if (owner >= 0) begin
        fire = (age == TO - 1) && !s_ack && !s_rty;
        e_grant = N'(1) << owner;
        e_bus = {m_cyc[owner] && !fire, m_stb[owner] && !fire, m_we[owner],
                 m_sel[owner*SW +: SW], m_adr[owner*AW +: AW], m_dat_m[owner*DW +: DW]};
        e_ack = s_ack ? e_grant : '0;
        e_rty = (s_rty || fire) ? e_grant : '0;
      end
      checks++;
      if (grant !== e_grant) begin
        fails++; $display("FAIL rand_grant@%0d: got %b required %b", cyc, grant, e_grant);
      end
      checks++;
      if ({s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_m} !== e_bus) begin
        fails++; $display("FAIL rand_bus@%0d: got %h required %h", cyc, {s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_m}, e_bus);
      end
      checks++;
      if ({m_ack, m_rty} !== {e_ack, e_rty}) begin
        fails++; $display("FAIL rand_resp@%0d: ack=%b rty=%b required %b %b", cyc, m_ack, m_rty, e_ack, e_rty);
      end
      checks++;
      if (timeout_flag !== mflags) begin
        fails++; $display("FAIL rand_flag@%0d: got %b required %b", cyc, timeout_flag, mflags);
      end
      checks++;
      if (m_dat_s !== s_dat_s) begin
        fails++; $display("FAIL rand_rdata@%0d: got %h required %h", cyc, m_dat_s, s_dat_s);
      end
      done = m_ack | m_rty;
      // advance the reference model across the coming clock edge
      setv = '0;
      if (owner >= 0) begin
        if (s_ack || s_rty || fire || !m_cyc[owner]) begin
          if (fire) setv = N'(1) << owner;
          rr = (owner + 1) % N;
          owner = -1;
        end else begin
          age++;
        end
      end else begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          if (w < 0 && m_cyc[(rr + k) % N] && m_stb[(rr + k) % N]) w = (rr + k) % N;
        end
        if (w >= 0) begin
          owner = w;
          age = 0;
        end
      end
      mflags = (timeout_clr ? '0 : mflags) | setv;
    end
    clear_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_fairness();
    test_routing();
    test_retry();
    test_watchdog();
    test_abort_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
